// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction-fetch fill path.
//   LINE_W          cache line width in bits (16-byte line)
//   OFS_W           byte-offset width within a line
//   t_fill_state    fill FSM state encoding
//   t_cache2i_mem_req / t_i_mem2cache_rsp   memory request / response bundles
//   line_align()    clears the byte-offset bits of an address
package ifu_pkg;
    localparam int LINE_W = 128;
    localparam int OFS_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL,
        ST_DRAIN
    } t_fill_state;

    typedef struct packed {
        logic [31:0] fill_requested_address;
        logic        fill_requested_address_valid;
    } t_cache2i_mem_req;

    typedef struct packed {
        logic [31:0]       fill_responded_address;
        logic [LINE_W-1:0] fill_data;
        logic              fill_valid;
    } t_i_mem2cache_rsp;

    localparam logic [31:0] OFS_MASK = 32'((1 << OFS_W) - 1);

    function automatic logic [31:0] line_align(input logic [31:0] a);
        return a & ~OFS_MASK;
    endfunction
endpackage

// File: rtl/ifu_fill_timer.sv
// ifu_fill_timer: response watchdog for the fill FSM.
//   clk, rst   clock, async active-low reset
//   en_i       count this cycle (FSM is in WAIT or DRAIN); low clears the count
//   expire_o   high in the TIMEOUT_CYCLES-th consecutive enabled cycle
module ifu_fill_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic expire_o
);
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count holds the number of enabled cycles already elapsed, so the
    // last allowed cycle is the one where the count reads TIMEOUT_CYCLES-1.
    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!en_i || expire_o) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ifu_fill_ctrl.sv
// ifu_fill_ctrl: instruction-cache miss fill controller.
// Accepts one miss at a time, issues a line request, waits for the matching
// response and writes the line into the tag/data arrays. Flush aborts the miss;
// a response already in flight is drained.
//   clk, rst          clock, async active-low reset
//   miss_valid/addr   miss from lookup; miss_ready high in IDLE
//   flush             abort outstanding miss
//   cache2i_mem_req   line request to memory (valid is a one-cycle pulse)
//   i_mem2cache_rsp   line response from memory
//   fill_valid/addr/data  one-cycle line write
//   busy              high outside IDLE
//   fill_err          one-cycle pulse when a miss is abandoned
// Optional macro FILL_TIMEOUT_EN: response watchdog with request re-issue.
module ifu_fill_ctrl #(
    parameter int LINE_W         = ifu_pkg::LINE_W,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRY      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      miss_valid,
    input  logic [31:0]               miss_addr,
    output logic                      miss_ready,
    input  logic                      flush,
    output ifu_pkg::t_cache2i_mem_req cache2i_mem_req,
    input  ifu_pkg::t_i_mem2cache_rsp i_mem2cache_rsp,
    output logic                      fill_valid,
    output logic [31:0]               fill_addr,
    output logic [LINE_W-1:0]         fill_data,
    output logic                      busy,
    output logic                      fill_err
);
    import ifu_pkg::*;

    if (TIMEOUT_CYCLES < 1 || MAX_RETRY < 0) begin : g_bad_cfg
        $error("ifu_fill_ctrl: TIMEOUT_CYCLES must be >= 1 and MAX_RETRY >= 0");
    end

    t_fill_state       state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic              rsp_hit;
    logic              expire;
    logic              retry_ok;
    logic              retry_inc;

    assign rsp_hit = i_mem2cache_rsp.fill_valid &&
                     (i_mem2cache_rsp.fill_responded_address == addr_q);

`ifdef FILL_TIMEOUT_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry_q;

    ifu_fill_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en_i     ((state_q == ST_WAIT) || (state_q == ST_DRAIN)),
        .expire_o (expire)
    );

    assign retry_ok = (32'(retry_q) < MAX_RETRY);

    // Retry count is cleared whenever a new miss is captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                       retry_q <= '0;
        else if (state_q == ST_IDLE)                    retry_q <= '0;
        else if (retry_inc)                             retry_q <= retry_q + RW'(1);
    end
`else
    assign expire   = 1'b0;
    assign retry_ok = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        retry_inc = 1'b0;
        fill_err  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (miss_valid && !flush) begin
                    addr_d  = line_align(miss_addr);
                    state_d = ST_REQ;
                end
            end
            ST_REQ: state_d = flush ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (flush) begin
                    // A hit coinciding with flush is already consumed; nothing left to drain.
                    state_d = rsp_hit ? ST_IDLE : ST_DRAIN;
                end else if (rsp_hit) begin
                    data_d  = i_mem2cache_rsp.fill_data;
                    state_d = ST_FILL;
                end else if (expire) begin
                    if (retry_ok) begin
                        retry_inc = 1'b1;
                        state_d   = ST_REQ;
                    end else begin
                        fill_err  = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_FILL:  state_d = ST_IDLE;
            ST_DRAIN: if (rsp_hit || expire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign miss_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign cache2i_mem_req.fill_requested_address       = busy ? addr_q : 32'd0;
    assign cache2i_mem_req.fill_requested_address_valid = (state_q == ST_REQ) && !flush;
    assign fill_valid = (state_q == ST_FILL) && !flush;
    assign fill_addr  = addr_q;
    assign fill_data  = data_q;
endmodule

// File: tb/tb_ifu_fill_ctrl.sv
module tb_ifu_fill_ctrl;
    import ifu_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              miss_valid = 1'b0;
    logic [31:0]       miss_addr = '0;
    logic              miss_ready;
    logic              flush = 1'b0;
    t_cache2i_mem_req  req;
    t_i_mem2cache_rsp  rsp = '0;
    logic              fill_valid;
    logic [31:0]       fill_addr;
    logic [LINE_W-1:0] fill_data;
    logic              busy;
    logic              fill_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifu_fill_ctrl #(.LINE_W(LINE_W), .TIMEOUT_CYCLES(8), .MAX_RETRY(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .miss_valid      (miss_valid),
        .miss_addr       (miss_addr),
        .miss_ready      (miss_ready),
        .flush           (flush),
        .cache2i_mem_req (req),
        .i_mem2cache_rsp (rsp),
        .fill_valid      (fill_valid),
        .fill_addr       (fill_addr),
        .fill_data       (fill_data),
        .busy            (busy),
        .fill_err        (fill_err)
    );

    typedef struct {
        logic              mv;
        logic [31:0]       ma;
        logic              fl;
        logic              rv;
        logic [31:0]       ra;
        logic [LINE_W-1:0] rd;
        logic              e_rdy;
        logic              e_req;
        logic [31:0]       e_raddr;
        logic              e_fv;
        logic [31:0]       e_faddr;
        logic [LINE_W-1:0] e_fdata;
        logic              e_busy;
    } vec_t;

    vec_t vq[$];

    localparam logic [LINE_W-1:0] D1 = 128'h00000004_00000003_00000002_00000001;
    localparam logic [LINE_W-1:0] D2 = 128'hA5A5A5A5_00000000_FFFFFFFF_12345678;
    localparam logic [LINE_W-1:0] D3 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [LINE_W-1:0] D4 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [LINE_W-1:0] DX = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;

    task automatic add(input logic mv, input logic [31:0] ma, input logic fl,
                       input logic rv, input logic [31:0] ra, input logic [LINE_W-1:0] rd,
                       input logic rdy, input logic rq, input logic [31:0] raddr,
                       input logic fv, input logic [31:0] faddr, input logic [LINE_W-1:0] fdata,
                       input logic bsy);
        vec_t v;
        v.mv = mv; v.ma = ma; v.fl = fl; v.rv = rv; v.ra = ra; v.rd = rd;
        v.e_rdy = rdy; v.e_req = rq; v.e_raddr = raddr; v.e_fv = fv;
        v.e_faddr = faddr; v.e_fdata = fdata; v.e_busy = bsy;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [31:0] ma, input logic fl,
                         input logic rv, input logic [31:0] ra, input logic [LINE_W-1:0] rd);
        miss_valid = mv; miss_addr = ma; flush = fl;
        rsp.fill_valid = rv; rsp.fill_responded_address = ra; rsp.fill_data = rd;
    endtask

    task automatic idle_in();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, '0);
    endtask

    int req_cnt;
    int err_cnt;
    int req_t[$];
    int err_t;

    initial begin
        // Seq A: basic miss 0x14 -> line 0x10, rsp 4 cycles after request
        add(1,32'h14,0, 0,0,0,   1,0,32'h00,0,0,0,0);
        add(0,0,0,      0,0,0,   0,1,32'h10,0,0,0,1);
        add(0,0,0,      0,0,0,   0,0,32'h10,0,0,0,1);
        add(0,0,0,      0,0,0,   0,0,32'h10,0,0,0,1);
        add(0,0,0,      0,0,0,   0,0,32'h10,0,0,0,1);
        add(0,0,0, 1,32'h10,D1,  0,0,32'h10,0,0,0,1);
        add(0,0,0,      0,0,0,   0,0,32'h10,1,32'h10,D1,1);
        add(0,0,0,      0,0,0,   1,0,32'h00,0,0,0,0);
        // Seq B: miss held during WAIT, non-matching rsp ignored
        add(1,32'h10,0, 0,0,0,   1,0,32'h00,0,0,0,0);
        add(1,32'h20,0, 0,0,0,   0,1,32'h10,0,0,0,1);
        add(1,32'h20,0, 0,0,0,   0,0,32'h10,0,0,0,1);
        add(1,32'h20,0, 1,32'h30,DX, 0,0,32'h10,0,0,0,1);
        add(1,32'h20,0, 0,0,0,   0,0,32'h10,0,0,0,1);
        add(1,32'h20,0, 1,32'h10,D2, 0,0,32'h10,0,0,0,1);
        add(1,32'h20,0, 0,0,0,   0,0,32'h10,1,32'h10,D2,1);
        add(1,32'h20,0, 0,0,0,   1,0,32'h00,0,0,0,0);
        add(0,0,0,      0,0,0,   0,1,32'h20,0,0,0,1);
        add(0,0,0, 1,32'h20,D3,  0,0,32'h20,0,0,0,1);
        add(0,0,0,      0,0,0,   0,0,32'h20,1,32'h20,D3,1);
        add(0,0,0,      0,0,0,   1,0,32'h00,0,0,0,0);
        // Seq C: flush 2 cycles after request -> DRAIN, flush in DRAIN ignored
        add(1,32'h40,0, 0,0,0,   1,0,32'h00,0,0,0,0);
        add(0,0,0,      0,0,0,   0,1,32'h40,0,0,0,1);
        add(0,0,0,      0,0,0,   0,0,32'h40,0,0,0,1);
        add(0,0,1,      0,0,0,   0,0,32'h40,0,0,0,1);
        add(0,0,1,      0,0,0,   0,0,32'h40,0,0,0,1);
        add(0,0,0, 1,32'h40,D4,  0,0,32'h40,0,0,0,1);
        add(0,0,0,      0,0,0,   1,0,32'h00,0,0,0,0);
        // Seq D: flush in REQ suppresses the pulse
        add(1,32'h50,0, 0,0,0,   1,0,32'h00,0,0,0,0);
        add(0,0,1,      0,0,0,   0,0,32'h50,0,0,0,1);
        add(0,0,0,      0,0,0,   1,0,32'h00,0,0,0,0);
        // Seq E: flush beats miss_valid in IDLE
        add(1,32'h60,1, 0,0,0,   1,0,32'h00,0,0,0,0);
        add(0,0,0,      0,0,0,   1,0,32'h00,0,0,0,0);
        // Seq F: flush together with matching rsp in WAIT -> IDLE
        add(1,32'h70,0, 0,0,0,   1,0,32'h00,0,0,0,0);
        add(0,0,0,      0,0,0,   0,1,32'h70,0,0,0,1);
        add(0,0,1, 1,32'h70,D1,  0,0,32'h70,0,0,0,1);
        add(0,0,0,      0,0,0,   1,0,32'h00,0,0,0,0);
        // Seq G: flush in FILL suppresses fill_valid
        add(1,32'h84,0, 0,0,0,   1,0,32'h00,0,0,0,0);
        add(0,0,0,      0,0,0,   0,1,32'h80,0,0,0,1);
        add(0,0,0, 1,32'h80,D4,  0,0,32'h80,0,0,0,1);
        add(0,0,1,      0,0,0,   0,0,32'h80,0,0,0,1);
        add(0,0,0,      0,0,0,   1,0,32'h00,0,0,0,0);

        // reset state
        #1;
        chk("rst_ready", miss_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_v", req.fill_requested_address_valid, 1'b0);
        chk("rst_req_a", req.fill_requested_address, 32'd0);
        chk("rst_fill_v", fill_valid, 1'b0);
        chk("rst_fill_a", fill_addr, 32'd0);
        chk("rst_fill_d", fill_data, '0);
        chk("rst_err", fill_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].mv, vq[i].ma, vq[i].fl, vq[i].rv, vq[i].ra, vq[i].rd);
            #1;
            chk($sformatf("v%0d_ready", i), miss_ready, vq[i].e_rdy);
            chk($sformatf("v%0d_req_v", i), req.fill_requested_address_valid, vq[i].e_req);
            chk($sformatf("v%0d_req_a", i), req.fill_requested_address, vq[i].e_raddr);
            chk($sformatf("v%0d_fill_v", i), fill_valid, vq[i].e_fv);
            chk($sformatf("v%0d_busy", i), busy, vq[i].e_busy);
            chk($sformatf("v%0d_err", i), fill_err, 1'b0);
            if (vq[i].e_fv) begin
                chk($sformatf("v%0d_fill_a", i), fill_addr, vq[i].e_faddr);
                chk($sformatf("v%0d_fill_d", i), fill_data, vq[i].e_fdata);
            end
        end

        // Reset mid-WAIT, then a late response must be ignored
        @(negedge clk); drive(1, 32'h90, 0, 0, 0, '0);
        @(negedge clk); idle_in();
        @(negedge clk);
        @(negedge clk);
        chk("w_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("mr_ready", miss_ready, 1'b1);
        chk("mr_busy", busy, 1'b0);
        chk("mr_req_a", req.fill_requested_address, 32'd0);
        chk("mr_fill_a", fill_addr, 32'd0);
        chk("mr_fill_d", fill_data, '0);
        chk("mr_err", fill_err, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); drive(0, 0, 0, 1, 32'h90, D2);
        #1 chk("late_busy", busy, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle_in();
            #1;
            chk($sformatf("late_fill_v%0d", k), fill_valid, 1'b0);
            chk($sformatf("late_busy%0d", k), busy, 1'b0);
        end

        // Watchdog behaviour
        req_cnt = 0; err_cnt = 0; err_t = -1;
        @(negedge clk); drive(1, 32'hA8, 0, 0, 0, '0);
        @(negedge clk); idle_in();
`ifdef FILL_TIMEOUT_EN
        for (int c = 0; c < 60; c++) begin
            #1;
            if (req.fill_requested_address_valid) begin
                req_cnt++;
                req_t.push_back(c);
                chk($sformatf("to_req_a%0d", req_cnt), req.fill_requested_address, 32'hA0);
            end
            if (fill_err) begin
                err_cnt++;
                err_t = c;
            end
            @(negedge clk);
        end
        chk("to_req_cnt", 32'(req_cnt), 32'd3);
        chk("to_err_cnt", 32'(err_cnt), 32'd1);
        if (req_t.size() == 3) begin
            chk("to_gap1", 32'(req_t[1] - req_t[0]), 32'd9);
            chk("to_gap2", 32'(req_t[2] - req_t[1]), 32'd9);
            chk("to_err_t", 32'(err_t - req_t[2]), 32'd8);
        end
        chk("to_busy", busy, 1'b0);
        chk("to_ready", miss_ready, 1'b1);
`else
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req.fill_requested_address_valid) req_cnt++;
            if (fill_err) err_cnt++;
            @(negedge clk);
        end
        chk("nt_req_cnt", 32'(req_cnt), 32'd1);
        chk("nt_err_cnt", 32'(err_cnt), 32'd0);
        chk("nt_busy", busy, 1'b1);
        // Park in DRAIN for a long time, then drain the response
        drive(0, 0, 1, 0, 0, '0);
        @(negedge clk); idle_in();
        for (int c = 0; c < 30; c++) @(negedge clk);
        #1 chk("nt_drain_busy", busy, 1'b1);
        drive(0, 0, 0, 1, 32'hA0, D3);
        #1 chk("nt_drain_fv", fill_valid, 1'b0);
        @(negedge clk); idle_in();
        #1;
        chk("nt_drain_fv2", fill_valid, 1'b0);
        chk("nt_drain_done", busy, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end
endmodule
